// File: rtl/ctx_switch_seq_pkg.sv
// Shared definitions for the context save/restore sequencer.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
// Register-bank aliases, transfer defaults and FSM state encodings.
package ctx_switch_seq_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    // Register aliases
    localparam logic [4:0] R_ZERO = 5'd0;
    localparam logic [4:0] RS1    = 5'd20;
    localparam logic [4:0] RS2    = 5'd21;
    localparam logic [4:0] RS3    = 5'd22;
    localparam logic [4:0] RS4    = 5'd23;
    localparam logic [4:0] RS5    = 5'd24;
    localparam logic [4:0] RS6    = 5'd25;
    localparam logic [4:0] RSP    = 5'd26;
    localparam logic [4:0] RBP    = 5'd27;
    localparam logic [4:0] RA     = 5'd28;
    localparam logic [4:0] RRET   = 5'd31;

    // Transfer defaults: r0 is hard-wired and never moved
    localparam int unsigned FIRST_REG_DEF  = 1;
    localparam int unsigned LAST_REG_DEF   = 31;
    localparam int unsigned SLOT_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        REST = 2'd2,
        DONE = 2'd3
    } state_e;

    // Byte address of a context slot; 32-bit modular, wrap is legal
    function automatic logic [31:0] slot_addr(input logic [31:0] base,
                                              input logic [4:0]  slot,
                                              input int unsigned stride);
        return base + ({27'd0, slot} * 32'(stride));
    endfunction

endpackage

// File: rtl/ctx_switch_seq_if.sv
// Memory-side bus of the context sequencer (single outstanding request).
// Latency: transfer completes in any cycle with a request high and mem_ready=1.
// Backpressure: mem_ready=0 stretches the current beat; requester holds all outputs.
// Members: mem_addr/mem_wdata/mem_we/mem_re driven by master, mem_rdata/mem_ready by slave.
interface ctx_switch_seq_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/ctx_switch_seq_iter.sv
// Register-index and context-slot counters for the save/restore walk.
// Latency: counters update on the posedge after init_i/adv_i; last_o is combinational.
// Backpressure: holds while adv_i is low (memory wait states).
// Ports: clk, reset (sync active-low), init_i, adv_i -> idx_o, slot_o, last_o.
// Build option SKIP_OS_REGS_EN: idx jumps over RS1..RS6 while slot stays contiguous.
module ctx_reg_iter
    import ctx_switch_seq_pkg::*;
#(
    parameter int unsigned FIRST_REG = FIRST_REG_DEF,
    parameter int unsigned LAST_REG  = LAST_REG_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_i,
    input  logic       adv_i,
    output logic [4:0] idx_o,
    output logic [4:0] slot_o,
    output logic       last_o
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef SKIP_OS_REGS_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    logic [4:0] idx_q,  idx_d;
    logic [4:0] slot_q, slot_d;
    logic [4:0] idx_inc;

    assign idx_inc = idx_q + 5'd1;

    always_comb begin
        idx_d  = idx_q;
        slot_d = slot_q;
        if (init_i) begin
            idx_d  = FIRST_IDX;
            slot_d = 5'd0;
        end else if (adv_i) begin
            // OS-reserved block is stepped over in one hop so slots stay dense
            if (SKIP_EN && (idx_inc == RS1)) begin
                idx_d = RS6 + 5'd1;
            end else begin
                idx_d = idx_inc;
            end
            slot_d = slot_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q  <= 5'd0;
            slot_q <= 5'd0;
        end else begin
            idx_q  <= idx_d;
            slot_q <= slot_d;
        end
    end

    assign idx_o  = idx_q;
    assign slot_o = slot_q;
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/ctx_switch_seq.sv
// Context-switch sequencer: saves/restores r1..r31 between the register bank and memory.
// Latency: zero-wait set = start cycle, one beat per cycle, done pulse, then IDLE.
// Backpressure: mem_ready=0 freezes the beat; CPU stalled (cpu_stall_o) whenever busy.
// Ports: clk, reset (sync active-low); start_save_i/start_rest_i/ctx_base_i requests;
//   busy_o/done_o/cpu_stall_o status; cpu_* pipeline write port; rf_* bank port;
//   mem (ctx_switch_seq_if.master) memory bus.
// Build option SKIP_OS_REGS_EN: skip RS1..RS6 (25 beats instead of 31).
module ctx_switch_seq
    import ctx_switch_seq_pkg::*;
#(
    parameter int unsigned FIRST_REG  = FIRST_REG_DEF,
    parameter int unsigned LAST_REG   = LAST_REG_DEF,
    parameter int unsigned SLOT_BYTES = SLOT_BYTES_DEF
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               start_save_i,
    input  logic               start_rest_i,
    input  logic [31:0]        ctx_base_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               cpu_stall_o,

    input  logic               cpu_we_i,
    input  logic [4:0]         cpu_waddr_i,
    input  logic [31:0]        cpu_wdata_i,

    output logic [4:0]         rf_raddr_o,
    input  logic [31:0]        rf_rdata_i,
    output logic               rf_we_o,
    output logic [4:0]         rf_waddr_o,
    output logic [31:0]        rf_wdata_o,

    ctx_switch_seq_if.master   mem
);

    state_e      state_q, state_d;
    logic [31:0] base_q,  base_d;

    logic        iter_init;
    logic        iter_adv;
    logic [4:0]  idx;
    logic [4:0]  slot;
    logic        last;
    logic        beat_ok;

    // A beat finishes only in a transfer state with the memory ready
    assign beat_ok  = ((state_q == SAVE) || (state_q == REST)) && mem.mem_ready;
    assign iter_adv = beat_ok;

    ctx_reg_iter #(
        .FIRST_REG (FIRST_REG),
        .LAST_REG  (LAST_REG)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .init_i (iter_init),
        .adv_i  (iter_adv),
        .idx_o  (idx),
        .slot_o (slot),
        .last_o (last)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        iter_init = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Save has priority; a simultaneous restore request is dropped
                if (start_save_i) begin
                    state_d   = SAVE;
                    base_d    = ctx_base_i;
                    iter_init = 1'b1;
                end else if (start_rest_i) begin
                    state_d   = REST;
                    base_d    = ctx_base_i;
                    iter_init = 1'b1;
                end
            end
            SAVE, REST: begin
                if (beat_ok && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Status
    assign busy_o      = (state_q != IDLE);
    assign cpu_stall_o = busy_o;
    assign done_o      = (state_q == DONE);

    // Memory side: outputs depend only on state/counters, so they hold during waits
    assign mem.mem_we    = (state_q == SAVE);
    assign mem.mem_re    = (state_q == REST);
    assign mem.mem_addr  = slot_addr(base_q, slot, SLOT_BYTES);
    assign mem.mem_wdata = rf_rdata_i;

    // Bank side: pipeline owns the write port only in IDLE
    assign rf_raddr_o = idx;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = idx;
        rf_wdata_o = mem.mem_rdata;
        if (state_q == IDLE) begin
            rf_we_o    = cpu_we_i;
            rf_waddr_o = cpu_waddr_i;
            rf_wdata_o = cpu_wdata_i;
        end else if (state_q == REST) begin
            rf_we_o    = mem.mem_ready;
        end
    end

endmodule

// File: tb/tb_ctx_switch_seq.sv
// Directed bench for ctx_switch_seq with a behavioural register bank and memory.
// Latency: n/a.
// Backpressure: memory wait states driven per cycle from the stimulus sequence.
module tb_ctx_switch_seq;
    import ctx_switch_seq_pkg::*;

`ifdef SKIP_OS_REGS_EN
    localparam int NBEATS = 25;
`else
    localparam int NBEATS = 31;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_save, start_rest;
    logic [31:0] ctx_base;
    logic        busy, done, cpu_stall;
    logic        cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_ready;

    logic [31:0] bank [0:31];
    logic [31:0] mem  [0:63];
    logic        bank_load;
    logic        mem_load;
    logic [31:0] mem_pat;
    int          wr_cnt;
    int          os_rd_cnt;
    int          both_cnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ctx_switch_seq_if mif ();

    assign mif.mem_ready = mem_ready;
    assign mif.mem_rdata = mem[mif.mem_addr[7:2]];
    assign rf_rdata      = bank[rf_raddr];

    ctx_switch_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start_save_i (start_save),
        .start_rest_i (start_rest),
        .ctx_base_i   (ctx_base),
        .busy_o       (busy),
        .done_o       (done),
        .cpu_stall_o  (cpu_stall),
        .cpu_we_i     (cpu_we),
        .cpu_waddr_i  (cpu_waddr),
        .cpu_wdata_i  (cpu_wdata),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_i   (rf_rdata),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .mem          (mif.master)
    );

    // Register bank: writes on negedge, preload pattern 0x100+N
    always @(negedge clk) begin
        if (bank_load) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'h100 + 32'(i);
        end else if (rf_we) begin
            bank[rf_waddr] <= rf_wdata;
        end
    end

    // Memory: 64 words indexed by address bits [7:2]
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= mem_pat + 32'(i);
        end else if (mif.mem_we && mif.mem_ready) begin
            mem[mif.mem_addr[7:2]] <= mif.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mif.mem_we && (rf_raddr >= RS1) && (rf_raddr <= RS6)) os_rd_cnt <= os_rd_cnt + 1;
        if (mif.mem_we && mif.mem_re) both_cnt <= both_cnt + 1;
    end

    initial begin
        wr_cnt    = 0;
        os_rd_cnt = 0;
        both_cnt  = 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nxt(input int r);
`ifdef SKIP_OS_REGS_EN
        if (r + 1 == 20) return 26;
`endif
        return r + 1;
    endfunction

    int          r;
    int          wr0;
    int          n_we, n_re;
    logic        got_done;

    initial begin
        reset = 1'b0; start_save = 1'b0; start_rest = 1'b0; ctx_base = 32'd0;
        cpu_we = 1'b0; cpu_waddr = 5'd0; cpu_wdata = 32'd0; mem_ready = 1'b0;
        bank_load = 1'b0; mem_load = 1'b0; mem_pat = 32'd0;

        // ---- Reset state ----
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we",   {31'd0, mif.mem_we}, 32'd0);
        chk("rst_re",   {31'd0, mif.mem_re}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        reset = 1'b1;
        bank_load = 1'b1; mem_load = 1'b1; mem_pat = 32'hEE00_0000;
        step();
        bank_load = 1'b0; mem_load = 1'b0;

        // ---- 1/5: zero-wait save, cpu writes ignored while busy ----
        wr0 = wr_cnt;
        start_save = 1'b1; ctx_base = 32'h1000; mem_ready = 1'b1;
        step();                                   // now cycle 1
        start_save = 1'b0; cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h0BAD;
        r = 1;
        for (int k = 0; k < NBEATS; k++) begin
            #1;
            chk("sv_we",    {31'd0, mif.mem_we}, 32'd1);
            chk("sv_addr",  mif.mem_addr, 32'h1000 + 32'(4 * k));
            chk("sv_wdata", mif.mem_wdata, 32'h100 + 32'(r));
            chk("sv_rfwe",  {31'd0, rf_we}, 32'd0);
            r = nxt(r);
            step();
        end
        cpu_we = 1'b0;
        #1;
        chk("sv_done",  {31'd0, done}, 32'd1);              // cycle NBEATS+1
        chk("sv_dbusy", {31'd0, busy}, 32'd1);
        step();
        chk("sv_idle",  {31'd0, busy}, 32'd0);
        chk("sv_dlow",  {31'd0, done}, 32'd0);
        chk("sv_cnt",   32'(wr_cnt - wr0), 32'(NBEATS));
        chk("sv_r1",    mem[0], 32'h101);
        chk("sv_r31",   mem[NBEATS-1], 32'h11F);
        chk("sv_r3keep", bank[3], 32'h103);
`ifdef SKIP_OS_REGS_EN
        chk("sk_r19",   mem[18], 32'h113);
        chk("sk_rsp",   mem[19], 32'h11A);
        chk("sk_osrd",  32'(os_rd_cnt), 32'd0);
`endif

        // ---- 5: IDLE pass-through ----
        cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'hDEAD0003;
        #1;
        chk("pt_we",    {31'd0, rf_we}, 32'd1);
        chk("pt_waddr", {27'd0, rf_waddr}, 32'd3);
        chk("pt_wdata", rf_wdata, 32'hDEAD0003);
        step();
        cpu_we = 1'b0;
        chk("pt_bank",  bank[3], 32'hDEAD0003);

        // ---- 2: restore with two wait cycles per beat ----
        bank_load = 1'b1; mem_load = 1'b1; mem_pat = 32'hA000;
        step();
        bank_load = 1'b0; mem_load = 1'b0;
        start_rest = 1'b1; ctx_base = 32'h1000; mem_ready = 1'b0;
        step();
        start_rest = 1'b0;
        r = 1;
        for (int b = 0; b < NBEATS; b++) begin
            for (int w = 0; w < 3; w++) begin
                mem_ready = (w == 2);
                #1;
                chk("rs_re",   {31'd0, mif.mem_re}, 32'd1);
                chk("rs_we",   {31'd0, mif.mem_we}, 32'd0);
                chk("rs_addr", mif.mem_addr, 32'h1000 + 32'(4 * b));
                chk("rs_rfwe", {31'd0, rf_we}, (w == 2) ? 32'd1 : 32'd0);
                if (w == 2) begin
                    chk("rs_waddr", {27'd0, rf_waddr}, 32'(r));
                    chk("rs_wdata", rf_wdata, 32'hA000 + 32'(b));
                end
                step();
            end
            r = nxt(r);
        end
        mem_ready = 1'b0;
        #1;
        chk("rs_done",  {31'd0, done}, 32'd1);               // cycle 3*NBEATS+1
        step();
        chk("rs_idle",  {31'd0, busy}, 32'd0);
        chk("rs_r5",    bank[5], 32'hA004);
        chk("rs_r31",   bank[31], 32'hA000 + 32'(NBEATS - 1));
        chk("rs_r0",    bank[0], 32'h100);

        // ---- 3: both starts together, base wraps past 2^32 ----
        start_save = 1'b1; start_rest = 1'b1; ctx_base = 32'hFFFF_FFF0; mem_ready = 1'b1;
        step();
        start_save = 1'b0; start_rest = 1'b0;
        n_we = 0; n_re = 0; got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            #1;
            if (mif.mem_we) begin
                if (n_we == 0) chk("bo_addr0", mif.mem_addr, 32'hFFFF_FFF0);
                if (n_we == 4) chk("bo_wrap",  mif.mem_addr, 32'h0000_0000);
                n_we++;
            end
            if (mif.mem_re) n_re++;
            if (done) begin
                got_done = 1'b1;
                start_rest = 1'b1;                        // must be ignored in DONE
            end
            step();
        end
        start_rest = 1'b0;
        chk("bo_gotdone", {31'd0, got_done}, 32'd1);
        chk("bo_nwe",   32'(n_we), 32'(NBEATS));
        chk("bo_nre",   32'(n_re), 32'd0);
        chk("bo_idle",  {31'd0, busy}, 32'd0);
        step();
        chk("bo_norest", {31'd0, busy}, 32'd0);
        chk("bo_nore",  {31'd0, mif.mem_re}, 32'd0);
        chk("strobes",  32'(both_cnt), 32'd0);

        // ---- 4: reset during beat 10 of a restore ----
        bank_load = 1'b1; mem_load = 1'b1; mem_pat = 32'hB000;
        step();
        bank_load = 1'b0; mem_load = 1'b0;
        start_rest = 1'b1; ctx_base = 32'h1000; mem_ready = 1'b1;
        step();
        start_rest = 1'b0;
        for (int k = 1; k < 10; k++) step();      // r1..r9 transfer in cycles 1..9
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        chk("ab_idx",   {27'd0, rf_waddr}, 32'd10);
        step();
        reset = 1'b1;
        #1;
        chk("ab_busy",  {31'd0, busy}, 32'd0);
        chk("ab_re",    {31'd0, mif.mem_re}, 32'd0);
        chk("ab_done",  {31'd0, done}, 32'd0);
        step();
        chk("ab_done2", {31'd0, done}, 32'd0);
        chk("ab_r1",    bank[1], 32'hB000);
        chk("ab_r9",    bank[9], 32'hB008);
        chk("ab_r10",   bank[10], 32'h10A);
        chk("ab_r31",   bank[31], 32'h11F);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
